// File: rtl/weight_fifo_to_buffer_tile_pkg.sv
// Shared constants, FSM encoding and parameter helpers for the weight FIFO to
// weight-buffer store stage.
package weight_fifo_to_buffer_tile_pkg;

  // Default tile geometry of the accelerator.
  localparam int DEF_K      = 3;
  localparam int DEF_TN     = 16;
  localparam int DEF_TM     = 16;
  localparam int KK         = DEF_K * DEF_K;
  localparam int TILE_WORDS = DEF_TM * DEF_TN * KK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } wf_state_e;

  // Words per (m,n) pair for kernel size k.
  function automatic int kk_of(input int k);
    return k * k;
  endfunction

  // Words in one Tm x Tn x K x K tile.
  function automatic int tile_words_of(input int tm, input int tn, input int k);
    return tm * tn * k * k;
  endfunction

  // A bank must hold Tm*K*K words: 2^aw >= tm*k*k.
  function automatic bit addr_fits(input int aw, input int tm, input int k);
    if (aw >= 31) return 1'b1;
    return (longint'(tm) * k * k) <= (longint'(1) << aw);
  endfunction

endpackage

// File: rtl/weight_fifo_to_buffer_tile_tile_idx_counter.sv
// Nested k/n/m tile index counter. k is innermost and wraps at KK-1, n wraps
// at TN-1, m wraps at TM-1. base tracks m*KK incrementally so the buffer
// address needs no multiplier.
module tile_idx_counter #(
  parameter int CW = 16,
  parameter int KK = 9,
  parameter int TN = 16,
  parameter int TM = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] k_idx,
  output logic [CW-1:0] n_idx,
  output logic [CW-1:0] base,
  output logic          last
);

  localparam logic [CW-1:0] K_MAX  = CW'(KK - 1);
  localparam logic [CW-1:0] N_MAX  = CW'(TN - 1);
  localparam logic [CW-1:0] M_MAX  = CW'(TM - 1);
  localparam logic [CW-1:0] KK_INC = CW'(KK);

  logic [CW-1:0] m_idx;
  logic          k_wrap;
  logic          n_wrap;
  logic          m_wrap;

  assign k_wrap = (k_idx == K_MAX);
  assign n_wrap = (n_idx == N_MAX);
  assign m_wrap = (m_idx == M_MAX);
  assign last   = k_wrap && n_wrap && m_wrap;

  // Advance k, carrying into n and then m; base follows m in steps of KK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_idx <= '0;
      n_idx <= '0;
      m_idx <= '0;
      base  <= '0;
    end else if (clr) begin
      k_idx <= '0;
      n_idx <= '0;
      m_idx <= '0;
      base  <= '0;
    end else if (en) begin
      if (!k_wrap) begin
        k_idx <= k_idx + 1'b1;
      end else begin
        k_idx <= '0;
        if (!n_wrap) begin
          n_idx <= n_idx + 1'b1;
        end else begin
          n_idx <= '0;
          if (!m_wrap) begin
            m_idx <= m_idx + 1'b1;
            base  <= base + KK_INC;
          end else begin
            m_idx <= '0;
            base  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/weight_fifo_to_buffer_tile.sv
// Drains one Tm x Tn x K x K weight tile from the weight FIFO (m-major,
// n-middle, k-innermost) into the input-channel-banked weight buffer.
// Word (m,n,k) goes to bank n at address m*KK + k, one cycle after its pop.
module weight_fifo_to_buffer_tile
  import weight_fifo_to_buffer_tile_pkg::*;
#(
  parameter int AW = 12,
  parameter int CW = 16,
  parameter int DW = 32,
  parameter int K  = 3,
  parameter int Tn = 16,
  parameter int Tm = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_start,
  output logic          store_done,
  input  logic          load_fifo_empty,
  output logic          load_fifo_pop,
  input  logic [DW-1:0] load_fifo_data,
  output logic          wbuf_wr_ena,
  output logic [Tn-1:0] wbuf_bank_sel,
  output logic [AW-1:0] wbuf_wr_addr,
  output logic [DW-1:0] wbuf_wr_data
);

  localparam int KSQ = kk_of(K);

  if (!addr_fits(AW, Tm, K)) begin : g_aw_check
    $error("weight_fifo_to_buffer_tile: AW too small for Tm*K*K words per bank");
  end

  wf_state_e     state;
  logic          start_run;
  logic          pop_last;
  logic [CW-1:0] k_p;
  logic [CW-1:0] n_p;
  logic [CW-1:0] base_p;
  logic          pop_d1;
  logic [CW-1:0] k_w;
  logic [CW-1:0] n_w;
  logic [CW-1:0] base_w;

  assign start_run     = (state == IDLE) && store_start;
  assign load_fifo_pop = (state == POP) && !load_fifo_empty;

  tile_idx_counter #(
    .CW (CW),
    .KK (KSQ),
    .TN (Tn),
    .TM (Tm)
  ) u_pop_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_run),
    .en    (load_fifo_pop),
    .k_idx (k_p),
    .n_idx (n_p),
    .base  (base_p),
    .last  (pop_last)
  );

  // Run control; store_done is registered and high exactly while in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      store_done <= 1'b0;
    end else begin
      store_done <= 1'b0;
      case (state)
        IDLE: if (store_start) state <= POP;
        POP:  if (load_fifo_pop && pop_last) state <= LAST;
        LAST: begin
          state      <= DONE;
          store_done <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Write-side indices: the pop indices delayed to line up with FIFO data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_d1 <= 1'b0;
      k_w    <= '0;
      n_w    <= '0;
      base_w <= '0;
    end else begin
      pop_d1 <= load_fifo_pop;
      k_w    <= k_p;
      n_w    <= n_p;
      base_w <= base_p;
    end
  end

  assign wbuf_wr_ena  = pop_d1;
  assign wbuf_wr_data = load_fifo_data;
  assign wbuf_wr_addr = AW'(base_w + k_w);

  // One-hot bank decode, gated so no bank is selected while not writing.
  always_comb begin
    wbuf_bank_sel = '0;
    for (int unsigned i = 0; i < Tn; i++) begin
      if (pop_d1 && (n_w == CW'(i))) wbuf_bank_sel[i] = 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_fifo_to_buffer_tile.sv
// Bench for weight_fifo_to_buffer_tile: a small K=3,Tn=Tm=2 instance for the
// functional scenarios and a default-size instance for the full-tile sweep.
module tb_weight_fifo_to_buffer_tile;

  localparam int S_KK = 9;
  localparam int S_TN = 2;
  localparam int S_TW = 36;
  localparam int B_KK = 9;
  localparam int B_TN = 16;
  localparam int B_TW = 2304;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- small instance ----------------
  logic        s_start;
  logic        s_done;
  logic        s_empty;
  logic        s_pop;
  logic [31:0] s_fdata;
  logic        s_ena;
  logic [1:0]  s_bank;
  logic [4:0]  s_addr;
  logic [31:0] s_wdata;

  weight_fifo_to_buffer_tile #(
    .AW (5), .CW (16), .DW (32), .K (3), .Tn (2), .Tm (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .store_start     (s_start),
    .store_done      (s_done),
    .load_fifo_empty (s_empty),
    .load_fifo_pop   (s_pop),
    .load_fifo_data  (s_fdata),
    .wbuf_wr_ena     (s_ena),
    .wbuf_bank_sel   (s_bank),
    .wbuf_wr_addr    (s_addr),
    .wbuf_wr_data    (s_wdata)
  );

  // FIFO model: data appears the cycle after a pop; empty may be forced by a random stall.
  logic [31:0] s_q[$];
  int          s_stall_pct = 0;
  always @(posedge clk) begin
    if (s_pop) begin
      check_val("s_no_overread", s_q.size() == 0, 1'b0);
      if (s_q.size() != 0) s_fdata <= s_q.pop_front();
    end
    #1;
    s_empty = (($urandom_range(99) < s_stall_pct) || (s_q.size() == 0));
  end

  // Write log and protocol checks.
  logic [31:0] log_d[$];
  logic [1:0]  log_b[$];
  logic [4:0]  log_a[$];
  int          s_done_cnt = 0;
  logic        s_prev_pop = 1'b0;
  always @(negedge clk) begin
    if (s_ena) begin
      log_d.push_back(s_wdata);
      log_b.push_back(s_bank);
      log_a.push_back(s_addr);
      check_val("s_ena_after_pop", s_prev_pop, 1'b1);
      check_val("s_bank_onehot", $onehot(s_bank), 1'b1);
    end
    if (s_done) s_done_cnt++;
    s_prev_pop = s_pop;
  end

  // ---------------- default-size instance ----------------
  logic        b_start;
  logic        b_done;
  logic        b_empty;
  logic        b_pop;
  logic [31:0] b_fdata;
  logic        b_ena;
  logic [15:0] b_bank;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;

  weight_fifo_to_buffer_tile dut_big (
    .clk             (clk),
    .rst             (rst),
    .store_start     (b_start),
    .store_done      (b_done),
    .load_fifo_empty (b_empty),
    .load_fifo_pop   (b_pop),
    .load_fifo_data  (b_fdata),
    .wbuf_wr_ena     (b_ena),
    .wbuf_bank_sel   (b_bank),
    .wbuf_wr_addr    (b_addr),
    .wbuf_wr_data    (b_wdata)
  );

  logic [31:0] b_q[$];
  always @(posedge clk) begin
    if (b_pop && (b_q.size() != 0)) b_fdata <= b_q.pop_front();
    #1;
    b_empty = (b_q.size() == 0);
  end

  int b_idx = 0;
  int b_cnt[B_TN];
  int b_max = 0;
  int b_i;
  logic [15:0] b_eb;
  always @(negedge clk) begin
    if (b_ena) begin
      b_i  = b_idx % B_TW;
      b_eb = 16'h0001 << ((b_i / B_KK) % B_TN);
      check_val("b_data", b_wdata, b_idx);
      check_val("b_bank", b_bank, b_eb);
      check_val("b_addr", b_addr, (b_i / (B_KK * B_TN)) * B_KK + b_i % B_KK);
      for (int j = 0; j < B_TN; j++) if (b_bank[j]) b_cnt[j]++;
      if (int'(b_addr) > b_max) b_max = int'(b_addr);
      b_idx++;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    log_d.delete();
    log_b.delete();
    log_a.delete();
    s_done_cnt = 0;
  endtask

  task automatic push_words(input int base_val, input int n);
    for (int j = 0; j < n; j++) s_q.push_back(32'(base_val + j));
    repeat (2) @(posedge clk);
  endtask

  // Pulse store_start, optionally re-pulse it 10 cycles in, and count cycles
  // from the start cycle to the store_done cycle.
  task automatic s_launch(input bit extra_start, output int cyc);
    bit got;
    @(posedge clk); #1;
    s_start = 1'b1;
    if (extra_start) begin
      fork
        begin
          repeat (10) @(posedge clk);
          #1 s_start = 1'b1;
          @(posedge clk);
          #1 s_start = 1'b0;
        end
      join_none
    end
    @(posedge clk); #1;
    s_start = 1'b0;
    cyc = 1;
    got = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (s_done) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    check_val("s_done_seen", got, 1'b1);
  endtask

  // Compare the logged writes with the tile order derived from word index.
  task automatic verify_log(input string tag, input int n, input int base_val);
    check_val({tag, "_count"}, log_d.size(), n);
    for (int j = 0; j < n && j < log_d.size(); j++) begin
      int i;
      logic [1:0] eb;
      i  = j % S_TW;
      eb = 2'b01 << ((i / S_KK) % S_TN);
      check_val({tag, "_data"}, log_d[j], 32'(base_val + j));
      check_val({tag, "_bank"}, log_b[j], eb);
      check_val({tag, "_addr"}, log_a[j], (i / (S_KK * S_TN)) * S_KK + i % S_KK);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int base_val;
    bit hit;

    rst     = 1'b0;
    s_start = 1'b0;
    b_start = 1'b0;
    s_empty = 1'b1;
    b_empty = 1'b1;
    s_fdata = '0;
    b_fdata = '0;
    foreach (b_cnt[j]) b_cnt[j] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_pop", s_pop, 1'b0);
    check_val("rst_ena", s_ena, 1'b0);
    check_val("rst_bank", s_bank, 2'b00);
    check_val("rst_addr", s_addr, 5'd0);
    check_val("rst_done", s_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic run, no stalls.
    clear_log();
    push_words(0, S_TW);
    s_launch(1'b0, cyc);
    check_val("basic_latency", cyc, 38);
    repeat (5) @(negedge clk);
    check_val("basic_done_cnt", s_done_cnt, 1);
    verify_log("basic", S_TW, 0);

    // Random empty stalls at 50%.
    clear_log();
    base_val = int'($urandom_range(1 << 20));
    push_words(base_val, S_TW);
    s_stall_pct = 50;
    s_launch(1'b0, cyc);
    s_stall_pct = 0;
    repeat (5) @(negedge clk);
    check_val("stall_done_cnt", s_done_cnt, 1);
    verify_log("stall", S_TW, base_val);

    // store_start re-pulsed mid-run must be ignored.
    clear_log();
    base_val = int'($urandom_range(1 << 20));
    push_words(base_val, S_TW);
    s_launch(1'b1, cyc);
    check_val("restart_latency", cyc, 38);
    repeat (15) @(negedge clk);
    check_val("restart_done_cnt", s_done_cnt, 1);
    verify_log("restart", S_TW, base_val);

    // Reset asserted at the 20th write aborts the run.
    clear_log();
    base_val = int'($urandom_range(1 << 20));
    push_words(base_val, S_TW);
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    hit = 1'b0;
    repeat (200) begin
      @(negedge clk);
      #1;
      if (log_d.size() == 20) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("rst_reach_20", hit, 1'b1);
    rst = 1'b0;
    #1;
    check_val("midrst_pop", s_pop, 1'b0);
    check_val("midrst_ena", s_ena, 1'b0);
    check_val("midrst_bank", s_bank, 2'b00);
    check_val("midrst_addr", s_addr, 5'd0);
    check_val("midrst_done", s_done, 1'b0);
    repeat (3) @(posedge clk);
    s_q.delete();
    #1 rst = 1'b1;
    repeat (6) @(negedge clk);
    check_val("midrst_no_more_writes", log_d.size(), 20);
    check_val("midrst_no_done", s_done_cnt, 0);
    verify_log("pre_rst", 20, base_val);
    clear_log();
    base_val = int'($urandom_range(1 << 20));
    push_words(base_val, S_TW);
    s_launch(1'b0, cyc);
    check_val("post_rst_latency", cyc, 38);
    repeat (5) @(negedge clk);
    verify_log("post_rst", S_TW, base_val);

    // Back-to-back tiles: second start the cycle after store_done.
    clear_log();
    base_val = int'($urandom_range(1 << 20));
    push_words(base_val, 2 * S_TW);
    s_launch(1'b0, cyc);
    check_val("b2b_first_latency", cyc, 38);
    s_launch(1'b0, cyc);
    check_val("b2b_second_latency", cyc, 38);
    repeat (5) @(negedge clk);
    check_val("b2b_done_cnt", s_done_cnt, 2);
    verify_log("b2b", 2 * S_TW, base_val);

    // Default-size tile.
    for (int j = 0; j < B_TW; j++) b_q.push_back(32'(j));
    repeat (2) @(posedge clk);
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    cyc = 1;
    hit = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (b_done) begin
        hit = 1'b1;
        break;
      end
      cyc++;
    end
    check_val("big_done_seen", hit, 1'b1);
    check_val("big_latency", cyc, B_TW + 2);
    repeat (3) @(negedge clk);
    check_val("big_writes", b_idx, B_TW);
    check_val("big_max_addr", b_max, 143);
    for (int j = 0; j < B_TN; j++) check_val($sformatf("big_bank%0d_cnt", j), b_cnt[j], 144);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
